// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module  : mem_access_unit
// Brief   : Load/store stage with a req/ack data bus. Build option
//           MEM_MISALIGN_TRAP_EN traps misaligned accesses instead of
//           silently dropping the low address bits.
// Rev     : 1.0  initial release
// ============================================================================
module mem_access_unit #(
  parameter int D_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_read_i,
  input  logic               mem_write_i,
  input  logic [2:0]         funct3_i,
  input  logic [D_WIDTH-1:0] alu_result_i,
  input  logic [D_WIDTH-1:0] write_data_i,
  output logic               stall_o,
  output logic [D_WIDTH-1:0] read_data_o,
  output logic               result_valid_o,
  output logic               misalign_err_o,
  output logic               dbus_req_o,
  output logic               dbus_we_o,
  output logic [D_WIDTH-1:0] dbus_addr_o,
  output logic [D_WIDTH-1:0] dbus_wdata_o,
  output logic [3:0]         dbus_be_o,
  input  logic               dbus_ack_i,
  input  logic [D_WIDTH-1:0] dbus_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [1:0]         off_q;
  logic [2:0]         f3_q;
  logic               req_q;
  logic               we_q;
  logic [D_WIDTH-1:0] addr_q;
  logic [D_WIDTH-1:0] wdata_q;
  logic [3:0]         be_q;
  logic [D_WIDTH-1:0] read_data_q;
  logic               result_valid_q;
  logic               misalign_q;

  logic               w_req;
  logic               w_trap;
  logic [3:0]         be_d;
  logic [D_WIDTH-1:0] wdata_d;
  logic [D_WIDTH-1:0] load_d;
  logic [7:0]         w_byte;
  logic [15:0]        w_half;

  assign w_req   = mem_read_i | mem_write_i;
  assign stall_o = ~rst & (((state_q == S_IDLE) & w_req) | (state_q == S_BUSY));

  // Size decode on funct3[1:0] is shared by loads and stores: 00 byte, 01 half, else word.
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = write_data_i;
    case (funct3_i[1:0])
      2'b00: begin
        be_d    = 4'b0001 << alu_result_i[1:0];
        wdata_d = {4{write_data_i[7:0]}};
      end
      2'b01: begin
        be_d    = alu_result_i[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{write_data_i[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  assign w_trap = (funct3_i[1:0] == 2'b01) ? alu_result_i[0]
                : ((funct3_i[1:0] != 2'b00) && (alu_result_i[1:0] != 2'b00));
`else
  assign w_trap = 1'b0;
`endif

  always_comb begin
    w_byte = dbus_rdata_i[{off_q, 3'b000} +: 8];
    w_half = off_q[1] ? dbus_rdata_i[31:16] : dbus_rdata_i[15:0];
    load_d = dbus_rdata_i;
    case (f3_q[1:0])
      2'b00:   load_d = {{(D_WIDTH-8){w_byte[7] & ~f3_q[2]}}, w_byte};
      2'b01:   load_d = {{(D_WIDTH-16){w_half[15] & ~f3_q[2]}}, w_half};
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      off_q          <= 2'b00;
      f3_q           <= 3'b000;
      req_q          <= 1'b0;
      we_q           <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      be_q           <= 4'b0000;
      read_data_q    <= '0;
      result_valid_q <= 1'b0;
      misalign_q     <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      misalign_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (w_req) begin
            off_q <= alu_result_i[1:0];
            f3_q  <= funct3_i;
            if (w_trap) begin
              state_q        <= S_DONE;
              result_valid_q <= 1'b1;
              misalign_q     <= 1'b1;
              read_data_q    <= '0;
            end else begin
              state_q <= S_BUSY;
              req_q   <= 1'b1;
              we_q    <= mem_write_i;
              addr_q  <= {alu_result_i[D_WIDTH-1:2], 2'b00};
              wdata_q <= wdata_d;
              be_q    <= be_d;
            end
          end
        end
        S_BUSY: begin
          if (dbus_ack_i) begin
            state_q        <= S_DONE;
            req_q          <= 1'b0;
            be_q           <= 4'b0000;
            result_valid_q <= 1'b1;
            if (!we_q) begin
              read_data_q <= load_d;
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign read_data_o    = read_data_q;
  assign result_valid_o = result_valid_q;
  assign misalign_err_o = misalign_q;
  assign dbus_req_o     = req_q;
  assign dbus_we_o      = we_q;
  assign dbus_addr_o    = addr_q;
  assign dbus_wdata_o   = wdata_q;
  assign dbus_be_o      = be_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_access_unit
// Brief   : Directed plus randomized load/store sequence for mem_access_unit,
//           checked against a byte-arithmetic reference model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] alu_result;
  logic [31:0] write_data;
  logic        stall;
  logic [31:0] read_data;
  logic        result_valid;
  logic        misalign_err;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [31:0] dbus_wdata;
  logic [3:0]  dbus_be;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;

  int n_cmp = 0;
  int n_err = 0;

  logic        e_we;
  logic        e_trap;
  logic [2:0]  e_f3;
  logic [31:0] e_raw_addr;
  logic [31:0] e_addr;
  logic [31:0] e_wdata;
  logic [3:0]  e_be;
  logic [31:0] exp_rd;

  mem_access_unit #(.D_WIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_read_i     (mem_read),
    .mem_write_i    (mem_write),
    .funct3_i       (funct3),
    .alu_result_i   (alu_result),
    .write_data_i   (write_data),
    .stall_o        (stall),
    .read_data_o    (read_data),
    .result_valid_o (result_valid),
    .misalign_err_o (misalign_err),
    .dbus_req_o     (dbus_req),
    .dbus_we_o      (dbus_we),
    .dbus_addr_o    (dbus_addr),
    .dbus_wdata_o   (dbus_wdata),
    .dbus_be_o      (dbus_be),
    .dbus_ack_i     (dbus_ack),
    .dbus_rdata_i   (dbus_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
  endfunction

  // Lane actually used: offset within the word, rounded down to the access size.
  function automatic int lane_of(input logic [31:0] addr, input int n);
    int off;
    off = int'(addr % 32'd4);
    return off - (off % n);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [31:0] addr);
    int          n;
    logic [31:0] mask;
    logic [31:0] v;
    n    = nbytes(f3);
    mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
    v    = (w >> (8 * lane_of(addr, n))) & mask;
    if (n < 4 && !f3[2] && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd, input logic exp_stall);
    int n;
    n          = nbytes(f3);
    mem_read   = rd;
    mem_write  = wr;
    funct3     = f3;
    alu_result = addr;
    write_data = wd;
    e_we       = wr;
    e_f3       = f3;
    e_raw_addr = addr;
    e_addr     = addr - (addr % 32'd4);
    e_be       = 4'(((1 << n) - 1) << lane_of(addr, n));
    e_wdata    = (n == 1) ? {24'd0, wd[7:0]} * 32'h0101_0101
               : (n == 2) ? {16'd0, wd[15:0]} * 32'h0001_0001 : wd;
`ifdef MEM_MISALIGN_TRAP_EN
    e_trap = (addr % n) != 0;
`else
    e_trap = 1'b0;
`endif
    #1;
    check("stall_on_request", {31'd0, stall}, {31'd0, exp_stall});
    check("req_before_busy", {31'd0, dbus_req}, 32'd0);
  endtask

  task automatic complete(input logic [31:0] rdata, input int delay);
    @(posedge clk); #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (e_trap) begin
      #1;
      exp_rd = 32'd0;
      check("trap_req", {31'd0, dbus_req}, 32'd0);
      check("trap_valid", {31'd0, result_valid}, 32'd1);
      check("trap_err", {31'd0, misalign_err}, 32'd1);
      check("trap_rdata", read_data, exp_rd);
      check("trap_stall", {31'd0, stall}, 32'd0);
    end else begin
      for (int i = 0; i <= delay; i++) begin
        if (i == delay) begin
          dbus_ack   = 1'b1;
          dbus_rdata = rdata;
        end else begin
          dbus_rdata = $urandom;
        end
        #1;
        check("busy_req", {31'd0, dbus_req}, 32'd1);
        check("busy_we", {31'd0, dbus_we}, {31'd0, e_we});
        check("busy_addr", dbus_addr, e_addr);
        check("busy_stall", {31'd0, stall}, 32'd1);
        check("busy_valid", {31'd0, result_valid}, 32'd0);
        if (e_we) begin
          check("busy_be", {28'd0, dbus_be}, {28'd0, e_be});
          check("busy_wdata", dbus_wdata, e_wdata);
        end
        @(posedge clk); #1;
      end
      dbus_ack = 1'b0;
      #1;
      if (!e_we) exp_rd = model_load(rdata, e_f3, e_raw_addr);
      check("done_valid", {31'd0, result_valid}, 32'd1);
      check("done_err", {31'd0, misalign_err}, 32'd0);
      check("done_rdata", read_data, exp_rd);
      check("done_req", {31'd0, dbus_req}, 32'd0);
      check("done_be", {28'd0, dbus_be}, 32'd0);
      check("done_stall", {31'd0, stall}, 32'd0);
    end
  endtask

  task automatic to_idle();
    @(posedge clk); #1;
    check("idle_valid", {31'd0, result_valid}, 32'd0);
    check("idle_err", {31'd0, misalign_err}, 32'd0);
    check("idle_stall", {31'd0, stall}, 32'd0);
    check("idle_req", {31'd0, dbus_req}, 32'd0);
  endtask

  initial begin
    logic        rd;
    logic        wr;
    rst        = 1'b1;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    funct3     = 3'b000;
    alu_result = 32'd0;
    write_data = 32'd0;
    dbus_ack   = 1'b0;
    dbus_rdata = 32'd0;
    exp_rd     = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", {31'd0, dbus_req}, 32'd0);
    check("rst_we", {31'd0, dbus_we}, 32'd0);
    check("rst_addr", dbus_addr, 32'd0);
    check("rst_wdata", dbus_wdata, 32'd0);
    check("rst_be", {28'd0, dbus_be}, 32'd0);
    check("rst_rdata", read_data, 32'd0);
    check("rst_valid", {31'd0, result_valid}, 32'd0);
    check("rst_err", {31'd0, misalign_err}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // SW, ack in the first bus cycle
    issue(1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 1'b1);
    complete(32'h0, 0);
    to_idle();

    // SB to the top lane, then LB / LBU from the same byte
    issue(1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 1'b1);
    complete(32'h0, 1);
    to_idle();
    issue(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 1'b1);
    complete(32'hA500_0000, 0);
    check("lb_const", read_data, 32'hFFFF_FFA5);
    to_idle();
    issue(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0, 1'b1);
    complete(32'hA500_0000, 0);
    check("lbu_const", read_data, 32'h0000_00A5);
    to_idle();

    // LH / LHU from the upper half
    issue(1'b1, 1'b0, 3'b001, 32'h0000_0202, 32'h0, 1'b1);
    complete(32'h8001_0000, 0);
    check("lh_const", read_data, 32'hFFFF_8001);
    to_idle();
    issue(1'b1, 1'b0, 3'b101, 32'h0000_0202, 32'h0, 1'b1);
    complete(32'h8001_0000, 0);
    check("lhu_const", read_data, 32'h0000_8001);
    to_idle();

    // Slow ack; a request raised in DONE is ignored and taken the cycle after
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0404, 32'h0, 1'b1);
    complete(32'h1234_5678, 3);
    issue(1'b0, 1'b1, 3'b001, 32'h0000_0406, 32'h0000_BEEF, 1'b0);
    @(posedge clk); #1;
    check("ignored_in_done_req", {31'd0, dbus_req}, 32'd0);
    check("ignored_in_done_valid", {31'd0, result_valid}, 32'd0);
    check("accept_after_done_stall", {31'd0, stall}, 32'd1);
    complete(32'h0, 0);
    check("store_keeps_rdata", read_data, 32'h1234_5678);
    to_idle();

    // Misaligned word load
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0, 1'b1);
    complete(32'hCAFE_F00D, 0);
    to_idle();

    // Both request lines at once behave as a store
    issue(1'b1, 1'b1, 3'b000, 32'h0000_0501, 32'h0000_003C, 1'b1);
    complete(32'hFFFF_FFFF, 0);
    to_idle();

    // Reset while the bus request is outstanding
    issue(1'b1, 1'b0, 3'b000, 32'h0000_0300, 32'h0, 1'b1);
    @(posedge clk); #1;
    mem_read = 1'b0;
    check("pre_rst_req", {31'd0, dbus_req}, 32'd1);
    rst = 1'b1;
    #1;
    check("async_rst_req", {31'd0, dbus_req}, 32'd0);
    check("async_rst_be", {28'd0, dbus_be}, 32'd0);
    check("async_rst_addr", dbus_addr, 32'd0);
    check("async_rst_rdata", read_data, 32'd0);
    check("async_rst_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    rst    = 1'b0;
    exp_rd = 32'd0;
    @(posedge clk); #1;
    check("post_rst_req", {31'd0, dbus_req}, 32'd0);
    check("post_rst_valid", {31'd0, result_valid}, 32'd0);
    check("post_rst_stall", {31'd0, stall}, 32'd0);

    // Randomized traffic
    repeat (40) begin
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      if (!rd && !wr) rd = 1'b1;
      issue(rd, wr, 3'($urandom_range(0, 7)), $urandom, $urandom, 1'b1);
      complete($urandom, $urandom_range(0, 3));
      to_idle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
